// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the receive and command blocks.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_PARITY  = 2'b01,
        ERR_STOP    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } ps2_err_e;

endpackage

// File: rtl/ps2_receive_if.sv
// Bus bundle between the PS/2 pins, the host gating and the byte consumer.
interface ps2_receive_if;
    import ps2_pkg::*;

    logic                     read_enable;
    logic                     ps2_clock;
    logic                     ps2_data;
    logic [PS2_DATA_BITS-1:0] data;
    logic                     data_valid;
    logic                     frame_error;
    ps2_err_e                 error_code;
    logic                     busy;

    modport master (
        output read_enable, ps2_clock, ps2_data,
        input  data, data_valid, frame_error, error_code, busy
    );

    modport slave (
        input  read_enable, ps2_clock, ps2_data,
        output data, data_valid, frame_error, error_code, busy
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronises the PS/2 clock/data lines and emits one filtered falling-edge pulse.
module ps2_sync_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic data_sync,
    output logic fe
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 2);
    localparam logic [CNT_W-1:0] FILT_FIRE = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [CNT_W-1:0]       filt_q, filt_d;
    logic                   clk_s;

    assign clk_s     = clk_sync_q[SYNC_STAGES-1];
    assign data_sync = dat_sync_q[SYNC_STAGES-1];

    // Counter parks one above the fire value so a long low phase yields a single fe.
    assign fe = (filt_q == FILT_FIRE);

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        filt_d     = filt_q;
        if (clk_s) begin
            filt_d = '0;
        end else if (filt_q != FILT_MAX) begin
            filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
        end
    end

endmodule

// File: rtl/ps2_receive.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB-first, odd parity, stop).
// Define PS2_RX_TIMEOUT_EN to add a mid-frame watchdog that aborts stalled frames.
module ps2_receive
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic          clk,
    input logic          reset,
    ps2_receive_if.slave bus
);

    localparam int BIT_W = $clog2(PS2_DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("ps2_receive: illegal parameter set");
    end

    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic data_sync, fe;

    ps2_sync_edge #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .ps2_clock(bus.ps2_clock),
        .ps2_data (bus.ps2_data),
        .data_sync(data_sync),
        .fe       (fe)
    );

    ps2_rx_state_e            state_q, state_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic [PS2_DATA_BITS-1:0] data_q, data_d;
    logic                     data_valid_q, data_valid_d;
    logic                     frame_error_q, frame_error_d;
    ps2_err_e                 err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     timeout;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    assign timeout = (wdog_q == WDOG_LIMIT);

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE || fe) begin
            wdog_d = '0;
        end else if (!timeout) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        data_d        = data_q;
        err_d         = err_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        // Host owns the bus: drop any partial frame silently.
        if (!bus.read_enable) begin
            state_d = IDLE;
        end else if (fe) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_sync) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_sync, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = data_sync;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!odd_parity_ok(shift_q, parity_q)) begin
                        frame_error_d = 1'b1;
                        err_d         = ERR_PARITY;
                    end else if (!data_sync) begin
                        frame_error_d = 1'b1;
                        err_d         = ERR_STOP;
                    end else begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        err_d        = ERR_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d       = IDLE;
            frame_error_d = 1'b1;
            err_d         = ERR_TIMEOUT;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            err_q         <= ERR_NONE;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.error_code  = err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ps2_receive.sv
// Directed self-checking bench for ps2_receive.
module tb_ps2_receive;
    import ps2_pkg::*;

    localparam int HALF = 20;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    ps2_receive_if bus ();

    ps2_receive #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (8),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.data_valid === 1'b1 && bus.frame_error === 1'b1) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v, input int half);
        bus.ps2_data = v;
        wait_cyc(half);
        bus.ps2_clock = 1'b0;
        wait_cyc(half);
        bus.ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
        ps2_bit(par, half);
        ps2_bit(stp, half);
        wait_cyc(half);
    endtask

    task automatic glitch();
        bus.ps2_clock = 1'b0;
        wait_cyc(3);
        bus.ps2_clock = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.read_enable = 1'b1;
        bus.ps2_clock = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(3);
        tests++; if (bus.data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.data); end
        tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.data_valid); end
        tests++; if (bus.frame_error !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", bus.frame_error); end
        tests++; if (bus.error_code !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", bus.error_code); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_good_frame();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 200);
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL good_valid_cnt: got %0d want 1", valid_cnt - v0); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL good_ferr_cnt: got %0d want 0", ferr_cnt - f0); end
        tests++; if (bus.data !== 8'h1C) begin fails++; $display("FAIL good_data: got %h want 1c", bus.data); end
        tests++; if (bus.error_code !== 2'b00) begin fails++; $display("FAIL good_err: got %b want 00", bus.error_code); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL good_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_latency();
        logic [7:0] b = 8'hA5;
        int lat = 0;
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], HALF);
        ps2_bit(1'b1, HALF);
        bus.ps2_data = 1'b1;
        wait_cyc(HALF);
        bus.ps2_clock = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.data_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        wait_cyc(HALF);
        bus.ps2_clock = 1'b1;
        wait_cyc(HALF);
        tests++; if (lat !== 11) begin fails++; $display("FAIL latency: got %0d want 11", lat); end
        tests++; if (bus.data !== 8'hA5) begin fails++; $display("FAIL latency_data: got %h want a5", bus.data); end
    endtask

    task automatic test_errors();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, HALF);
        tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL parity_ferr_cnt: got %0d want 1", ferr_cnt - f0); end
        tests++; if (bus.error_code !== 2'b01) begin fails++; $display("FAIL parity_err: got %b want 01", bus.error_code); end
        tests++; if (bus.data !== 8'hA5) begin fails++; $display("FAIL parity_data_hold: got %h want a5", bus.data); end
        send_frame(8'h5A, 1'b1, 1'b0, HALF);
        tests++; if (ferr_cnt - f0 !== 2) begin fails++; $display("FAIL stop_ferr_cnt: got %0d want 2", ferr_cnt - f0); end
        tests++; if (bus.error_code !== 2'b10) begin fails++; $display("FAIL stop_err: got %b want 10", bus.error_code); end
        send_frame(8'h5A, 1'b0, 1'b0, HALF);
        tests++; if (bus.error_code !== 2'b01) begin fails++; $display("FAIL both_err_prec: got %b want 01", bus.error_code); end
        tests++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL errors_no_valid: got %0d want 0", valid_cnt - v0); end
        tests++; if (bus.data !== 8'hA5) begin fails++; $display("FAIL errors_data_hold: got %h want a5", bus.data); end
    endtask

    task automatic test_read_enable_abort();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, HALF);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
        bus.read_enable = 1'b0;
        wait_cyc(3);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy_after: got %b want 0", bus.busy); end
        send_frame(8'h1C, 1'b0, 1'b1, HALF);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL disabled_busy: got %b want 0", bus.busy); end
        bus.read_enable = 1'b1;
        wait_cyc(HALF);
        send_frame(8'h29, 1'b0, 1'b1, HALF);
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL abort_valid_cnt: got %0d want 1", valid_cnt - v0); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL abort_ferr_cnt: got %0d want 0", ferr_cnt - f0); end
        tests++; if (bus.data !== 8'h29) begin fails++; $display("FAIL abort_data: got %h want 29", bus.data); end
        tests++; if (bus.error_code !== 2'b00) begin fails++; $display("FAIL abort_err: got %b want 00", bus.error_code); end
    endtask

    task automatic test_glitch();
        logic [7:0] b = 8'h1C;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        bus.ps2_data = 1'b0;
        glitch();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_idle_busy: got %b want 0", bus.busy); end
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 3; i++) ps2_bit(b[i], HALF);
        bus.ps2_data = ~b[3];
        glitch();
        for (int i = 3; i < 8; i++) ps2_bit(b[i], HALF);
        ps2_bit(1'b0, HALF);
        ps2_bit(1'b1, HALF);
        wait_cyc(HALF);
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL glitch_valid_cnt: got %0d want 1", valid_cnt - v0); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL glitch_ferr_cnt: got %0d want 0", ferr_cnt - f0); end
        tests++; if (bus.data !== 8'h1C) begin fails++; $display("FAIL glitch_data: got %h want 1c", bus.data); end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        send_frame(8'h29, 1'b0, 1'b1, HALF);
        tests++; if (bus.data !== 8'h29) begin fails++; $display("FAIL b2b_first: got %h want 29", bus.data); end
        send_frame(8'h76, 1'b0, 1'b1, HALF);
        tests++; if (bus.data !== 8'h76) begin fails++; $display("FAIL b2b_second: got %h want 76", bus.data); end
        tests++; if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_valid_cnt: got %0d want 2", valid_cnt - v0); end
    endtask

    task automatic test_stall();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, HALF);
`ifdef PS2_RX_TIMEOUT_EN
        begin
            int seen = 0;
            for (int k = 0; k < 1500; k++) begin
                @(negedge clk);
                if (ferr_cnt != f0) begin
                    seen = 1;
                    break;
                end
            end
            wait_cyc(3);
            tests++; if (seen !== 1) begin fails++; $display("FAIL timeout_seen: got %0d want 1", seen); end
            tests++; if (bus.error_code !== 2'b11) begin fails++; $display("FAIL timeout_err: got %b want 11", bus.error_code); end
            tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
            send_frame(8'h76, 1'b0, 1'b1, HALF);
            tests++; if (bus.data !== 8'h76) begin fails++; $display("FAIL timeout_next_data: got %h want 76", bus.data); end
            tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL timeout_valid_cnt: got %0d want 1", valid_cnt - v0); end
        end
`else
        wait_cyc(1500);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b want 1", bus.busy); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL stall_ferr_cnt: got %0d want 0", ferr_cnt - f0); end
        bus.read_enable = 1'b0;
        wait_cyc(3);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stall_release_busy: got %b want 0", bus.busy); end
        tests++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL stall_valid_cnt: got %0d want 0", valid_cnt - v0); end
        bus.read_enable = 1'b1;
        wait_cyc(HALF);
`endif
    endtask

    task automatic test_reset_mid_frame();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, HALF);
        reset = 1'b0;
        wait_cyc(2);
        tests++; if (bus.data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h want 00", bus.data); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        reset = 1'b1;
        for (int i = 3; i < 8; i++) ps2_bit(1'b1, HALF);
        wait_cyc(HALF);
        tests++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
            fails++; $display("FAIL midrst_pulses: got %0d/%0d want 0/0", valid_cnt - v0, ferr_cnt - f0);
        end
        send_frame(8'h1C, 1'b0, 1'b1, HALF);
        tests++; if (bus.data !== 8'h1C) begin fails++; $display("FAIL midrst_recover: got %h want 1c", bus.data); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_latency();
        test_errors();
        test_read_enable_abort();
        test_glitch();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL valid_ferr_overlap: got %0d want 0", overlap_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
